// File: rtl/dsi_tx_pixel_unpacker.sv
// DSI TX pixel unpacker: splits 32-bit show-ahead pixel-buffer words into an LSB-first byte
// stream for the packet assembler, one line at a time. Optional DSI_TX_UNPACKER_UNDERFLOW_CNT_EN.
module dsi_tx_pixel_unpacker #(
    parameter int unsigned BYTE_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               fifo_data,
    input  logic                      fifo_not_empty,
    input  logic                      fifo_line_ready,
    output logic                      fifo_read_ack,
    input  logic                      line_start,
    input  logic [BYTE_CNT_WIDTH-1:0] line_bytes,
    output logic                      busy,
    output logic                      line_done,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]               underflow_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitLine,
        StStream
    } state_t;

    state_t                    state_q;
    logic [1:0]                lane_q;
    logic [BYTE_CNT_WIDTH-1:0] remaining_q;
    logic                      line_done_q;

    logic       streaming;
    logic       xfer;
    logic       is_last;
    logic [7:0] lane_byte;

    assign streaming = (state_q == StStream);
    assign is_last   = (remaining_q == BYTE_CNT_WIDTH'(1));
    assign xfer      = out_valid & out_ready;

    always_comb begin
        lane_byte = 8'h00;
        unique case (lane_q)
            2'd0: lane_byte = fifo_data[7:0];
            2'd1: lane_byte = fifo_data[15:8];
            2'd2: lane_byte = fifo_data[23:16];
            2'd3: lane_byte = fifo_data[31:24];
            default: lane_byte = 8'h00;
        endcase
    end

    // Output path is combinational from the show-ahead word; gated so idle/reset reads as zero.
    always_comb begin
        out_valid     = streaming & fifo_not_empty;
        out_data      = out_valid ? lane_byte : 8'h00;
        out_last      = streaming & is_last;
        fifo_read_ack = out_valid & out_ready & ((lane_q == 2'd3) | is_last);
        busy          = (state_q != StIdle);
        line_done     = line_done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lane_q      <= 2'd0;
            remaining_q <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (line_start) begin
                        if (line_bytes != '0) begin
                            remaining_q <= line_bytes;
                            lane_q      <= 2'd0;
                            state_q     <= StWaitLine;
                        end else begin
                            line_done_q <= 1'b1;
                        end
                    end
                end
                StWaitLine: begin
                    if (fifo_line_ready) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (xfer) begin
                        remaining_q <= remaining_q - BYTE_CNT_WIDTH'(1);
                        lane_q      <= lane_q + 2'd1;
                        if (is_last) begin
                            state_q     <= StIdle;
                            line_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
    logic stalled;
    logic stall_q;

    // Count rising edges of the stalled condition; stall_q is 0 outside STREAM so an
    // empty buffer on STREAM entry also counts.
    assign stalled = streaming & ~fifo_not_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q       <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else begin
            stall_q <= stalled;
            if (stalled && !stall_q && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsi_tx_pixel_unpacker.sv
// Scoreboard bench for dsi_tx_pixel_unpacker: a byte-level line model fills an expectation
// queue at line_start; a negedge monitor compares every transfer, pop and line_done pulse.
module tb_dsi_tx_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack;
    logic        line_start;
    logic [15:0] line_bytes;
    logic        busy;
    logic        line_done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    dsi_tx_pixel_unpacker #(.BYTE_CNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_data       (fifo_data),
        .fifo_not_empty  (fifo_not_empty),
        .fifo_line_ready (fifo_line_ready),
        .fifo_read_ack   (fifo_read_ack),
        .line_start      (line_start),
        .line_bytes      (line_bytes),
        .busy            (busy),
        .line_done       (line_done),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last)
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt   (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ack;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          xfer_cnt = 0;
    int          zl_cnt = 0;
    int          zl_seen = 0;
    logic        pop_req = 1'b0;
    logic        force_empty = 1'b0;
    logic        empty_rand = 1'b0;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_not_empty = (fifo_q.size() != 0) && !force_empty;
        fifo_data      = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    // The buffer model pops on the edge following a cycle in which the DUT acked.
    task automatic tick();
        @(posedge clk);
        if (pop_req && fifo_q.size() != 0) fifo_q.delete(0);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (empty_rand) force_empty = ($urandom_range(0, 3) == 0);
        drive_fifo();
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // Reference model: byte i of a line is byte (i mod 4) of word i/4, popped every 4th or last.
    task automatic start_line(input int n);
        exp_t        e;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w      = (i / 4 < fifo_q.size()) ? fifo_q[i / 4] : 32'h0;
            e.data = w[8 * (i % 4) +: 8];
            e.last = (i == n - 1);
            e.ack  = ((i % 4) == 3) || (i == n - 1);
            exp_q.push_back(e);
        end
        line_bytes = 16'(n);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!line_done && cycles < 400) begin
            tick();
            cycles++;
        end
        check({name, "_line_done"}, 32'(line_done), 32'd1);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_xfers(input int target);
        int k = 0;
        while (xfer_cnt < target && k < 200) begin
            tick();
            k++;
        end
        check("xfer_wait", 32'(xfer_cnt >= target), 32'd1);
    endtask

    // Monitor: all per-cycle scoreboard checks happen away from the active edge.
    logic       prev_due = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_t       mon_e;

    always @(negedge clk) begin
        pop_req = fifo_read_ack;
        if (rst) begin
            prev_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (line_done && !prev_due && zl_cnt > zl_seen) begin
                zl_seen++;
            end else if (line_done || prev_due) begin
                check("line_done_timing", 32'(line_done), 32'(prev_due));
            end
            prev_due = 1'b0;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte", {24'h0, out_data}, {24'h0, mon_e.data});
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                    check("read_ack", 32'(fifo_read_ack), 32'(mon_e.ack));
                    prev_due = mon_e.last;
                end
            end else if (fifo_read_ack) begin
                check("ack_without_xfer", 32'(fifo_read_ack), 32'd0);
            end
            if (prev_stall && out_valid) check("stall_stable", {24'h0, out_data}, {24'h0, prev_data});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_read_ack"}, 32'(fifo_read_ack), 32'd0);
        check({name, "_line_done"}, 32'(line_done), 32'd0);
        check({name, "_out_data"}, {24'h0, out_data}, 32'd0);
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
        check({name, "_underflow"}, {16'h0, underflow_cnt}, 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        int base;
        int n;
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
        logic [15:0] uf_before;
`endif
        rst = 1'b1;
        line_start = 1'b0;
        line_bytes = 16'h0;
        fifo_line_ready = 1'b1;
        out_ready = 1'b1;
        drive_fifo();
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Two-word line, full throughput.
        push_word(32'h4433_2211);
        push_word(32'h8877_6655);
        push_word(32'hDDCC_BBAA);
        push_word(32'h0403_0201);
        start_line(8);
        wait_done("l8", cyc);
        check("l8_cycles", 32'(cyc), 32'd9);

        // Partial final word discarded; next line back-to-back from the following word.
        start_line(6);
        wait_done("l6", cyc);
        check("l6_cycles", 32'(cyc), 32'd7);
        check("l6_words_left", 32'(fifo_q.size()), 32'd0);
        push_word(32'h1234_5678);
        start_line(4);
        wait_done("l4", cyc);

        // Line not yet buffered: hold off for 20 cycles.
        push_word(32'hCAFE_F00D);
        fifo_line_ready = 1'b0;
        start_line(4);
        for (int i = 0; i < 20; i++) begin
            check("wait_out_valid", 32'(out_valid), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            tick();
        end
        fifo_line_ready = 1'b1;
        tick();
        check("stream_after_ready", 32'(out_valid), 32'd1);
        wait_done("lwait", cyc);

        // Back-pressure plus a 3-cycle buffer underrun after byte 2.
        push_word(32'hA3A2_A1A0);
        push_word(32'hB3B2_B1B0);
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
        uf_before = underflow_cnt;
`endif
        ready_mode = 1;
        base = xfer_cnt;
        start_line(8);
        wait_xfers(base + 2);
        force_empty = 1'b1;
        drive_fifo();
        repeat (3) tick();
        force_empty = 1'b0;
        drive_fifo();
        wait_done("lstall", cyc);
        ready_mode = 0;
`ifdef DSI_TX_UNPACKER_UNDERFLOW_CNT_EN
        check("underflow_cnt", {16'h0, underflow_cnt}, {16'h0, uf_before + 16'd1});
`endif
        tick();

        // Zero-length line.
        zl_cnt++;
        line_bytes = 16'h0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("zl_line_done", 32'(line_done), 32'd1);
        check("zl_busy", 32'(busy), 32'd0);
        tick();
        check("zl_done_single", 32'(line_done), 32'd0);

        // line_start while busy must be ignored.
        push_word(32'h5555_1111);
        push_word(32'h6666_2222);
        push_word(32'h7777_3333);
        start_line(4);
        line_bytes = 16'd8;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_done("lbusy", cyc);
        repeat (15) tick();
        check("busy_start_ignored", 32'(busy), 32'd0);

        // Reset mid-line after byte 5 of 12: word 2 stays at the buffer head.
        push_word(32'h8888_4444);
        base = xfer_cnt;
        start_line(12);
        wait_xfers(base + 5);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_words_left", 32'(fifo_q.size()), 32'd2);
        start_line(4);
        wait_done("post_rst", cyc);

        // Randomized lines.
        for (int l = 0; l < 30; l++) begin
            n = $urandom_range(1, 20);
            for (int w = 0; w < (n + 3) / 4 + $urandom_range(0, 1); w++) push_word($urandom);
            ready_mode = $urandom_range(0, 2);
            empty_rand = 1'($urandom_range(0, 1));
            fifo_line_ready = 1'($urandom_range(0, 1));
            start_line(n);
            if (!fifo_line_ready) begin
                repeat ($urandom_range(1, 4)) tick();
                fifo_line_ready = 1'b1;
            end
            wait_done("rand", cyc);
        end
        empty_rand = 1'b0;
        force_empty = 1'b0;
        ready_mode = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dsi_tx_pixel_unpacker.md
DSI_TX_PIXEL_UNPACKER -- requirements
Module: dsi_tx_pixel_unpacker

Interface
REQ-001 SHALL have parameter BYTE_CNT_WIDTH, default 16: width of the line byte counter and of line_bytes.
REQ-002 SHALL have port clk, input, 1: single clock; all logic is in this domain.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port fifo_data, input, 32: show-ahead pixel word from the TX pixel buffer; valid whenever fifo_not_empty=1.
REQ-005 SHALL have port fifo_not_empty, input, 1: buffer holds at least one word.
REQ-006 SHALL have port fifo_line_ready, input, 1: buffer holds at least one full line.
REQ-007 SHALL have port fifo_read_ack, output, 1: single-cycle pop of the current word.
REQ-008 SHALL have port line_start, input, 1: single-cycle request to emit one line.
REQ-009 SHALL have port line_bytes, input, BYTE_CNT_WIDTH: payload byte count; sampled when line_start is accepted.
REQ-010 SHALL have port busy, output, 1: a line is in progress.
REQ-011 SHALL have port line_done, output, 1: single-cycle pulse at line completion.
REQ-012 SHALL have port out_data, output, 8: payload byte to the packet assembler.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: the assembler accepts the byte.
REQ-015 SHALL have port out_last, output, 1: the current byte is the last byte of the line.

Function
REQ-016 SHALL implement states IDLE, WAIT_LINE and STREAM; busy=1 in WAIT_LINE and STREAM.
REQ-017 SHALL, in IDLE with line_start=1 and line_bytes!=0, latch line_bytes, clear byte lane to 0 and enter WAIT_LINE on the next edge.
REQ-018 SHALL, for line_start=1 with line_bytes=0 in IDLE, pulse line_done on the next cycle, stay in IDLE and issue no fifo_read_ack.
REQ-019 SHALL ignore line_start while busy=1.
REQ-020 SHALL move from WAIT_LINE to STREAM on the edge where fifo_line_ready=1.
REQ-021 SHALL, in STREAM, drive out_valid=fifo_not_empty and out_data=fifo_data[8*lane+7:8*lane], with lane 0 taking bits 7:0 (LSB-first); the output path is combinational from fifo_data.
REQ-022 SHALL advance a transfer only on out_valid & out_ready; each transfer decrements the remaining-byte count and increments lane modulo 4.
REQ-023 SHALL assert fifo_read_ack combinationally in the transfer cycle when lane=3 or the byte is the last of the line; a partial final word's unused bytes are discarded with that word.
REQ-024 SHALL assert out_last when the remaining count is 1 and state is STREAM.
REQ-025 SHALL, on the last transfer, return to IDLE and pulse line_done in the following cycle.
REQ-026 SHALL hold out_valid=0 and stall, with no data loss, if fifo_not_empty=0 during STREAM; resumes at the same lane.
REQ-027 SHALL keep out_data stable while out_valid=1 and out_ready=0, since no pop occurs.
REQ-028 SHALL have back-to-back throughput of 1 byte per clk with the earliest next line_start in the cycle line_done pulses.

Reset
REQ-029 SHALL, on rst=1, immediately enter IDLE and zero lane, count, busy, line_done, out_valid, out_last and fifo_read_ack, with out_data at 0 (gated).
REQ-030 SHALL, on reset mid-line, pop nothing further and not pulse line_done; buffer contents are not flushed by this block.

Configuration
REQ-031 SHALL, when DSI_TX_UNPACKER_UNDERFLOW_CNT_EN is defined, add output underflow_cnt[15:0], saturating at 0xFFFF, incremented once per STREAM entry into the stalled condition (fifo_not_empty 1->0 or entering STREAM empty), cleared only by rst.
REQ-032 SHALL, without the macro, have no underflow_cnt port and no counter logic.

Verification
REQ-033 SHALL have a bench pass the scenario line_bytes=8, FIFO words 0x44332211, 0x88776655, out_ready=1: bytes 11..88 on consecutive cycles, fifo_read_ack on bytes 4 and 8, out_last on byte 8, line_done 1 cycle later.
REQ-034 SHALL have a bench pass the scenario line_bytes=6: 6 bytes, 2 pops, bytes 3-4 of word 2 discarded, next line starts from word 3 lane 0.
REQ-035 SHALL have a bench pass the scenario fifo_line_ready=0 for 20 cycles after line_start: out_valid=0 and busy=1 throughout; streaming begins the cycle after fifo_line_ready rises.
REQ-036 SHALL have a bench pass the scenario out_ready toggling 1/0 and fifo_not_empty dropped for 3 cycles after byte 2: byte order intact, out_data stable when stalled, underflow_cnt=1 (macro on).
REQ-037 SHALL have a bench pass the scenario of line_bytes=0 and line_start during busy: line_done after 1 cycle, no pops; the busy-time line_start is ignored.
REQ-038 SHALL have a bench pass the scenario of rst asserted after byte 5 of 12: all outputs 0 immediately, state IDLE, no line_done.
